spi_burst_seq: RTL and testbench

- Burst sequencer and bus arbiter in front of the ATmega SPI master.
- Streams a block of bytes from a RAM port out through the master's SPCR/SPSR/SPDR register interface, optionally writing received bytes back in place. Typical use: the OLED frame push.
- While a burst runs, the block owns the master's I/O bus; otherwise CPU I/O accesses pass straight through.

---
 rtl/spi_burst_seq.sv | 212 +++++++++++++++++++++
 tb/tb_spi_burst_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_seq.sv
// spi_burst_seq: burst sequencer and I/O bus arbiter in front of the SPI master.
//
// Streams a block of RAM bytes through the master's SPCR/SPSR/SPDR register
// interface and can write each received byte back in place. The CPU's I/O
// accesses pass straight through while idle. During a burst, CPU accesses to
// SPI addresses stall and all other CPU accesses are dropped.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              one-cycle burst request (honoured only in IDLE)
//   base_addr, length  first RAM byte and byte count, latched on start
//   rx_en              write received bytes back to RAM
//   abort              stop after the byte in flight
//   busy, done         burst in progress / one-cycle completion pulse
//   aborted            last burst was ended by abort
//   cs_n               slave select, low while bytes are moving
//   mem_*              RAM port (read data valid the cycle after mem_rd)
//   cpu_*              CPU I/O side
//   spi_*              SPI master register bus, interrupt and interrupt clear
module spi_burst_seq #(
    parameter int unsigned                  BUS_ADDR_DATA_LEN = 8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] SPCR_ADDR         = 'h20,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] SPSR_ADDR         = 'h21,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] SPDR_ADDR         = 'h22,
    parameter logic [7:0]                   SPCR_CFG          = 8'hD0,
    parameter int unsigned                  MEM_ADDR_LEN      = 12,
    parameter int unsigned                  LEN_W             = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [MEM_ADDR_LEN-1:0]      base_addr,
    input  logic [LEN_W-1:0]             length,
    input  logic                         rx_en,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted,
    output logic                         cs_n,
    output logic [MEM_ADDR_LEN-1:0]      mem_addr,
    output logic                         mem_rd,
    input  logic [7:0]                   mem_dat_in,
    output logic                         mem_wr,
    output logic [7:0]                   mem_dat_out,
    input  logic [BUS_ADDR_DATA_LEN-1:0] cpu_addr,
    input  logic                         cpu_wr,
    input  logic                         cpu_rd,
    input  logic [7:0]                   cpu_dat_in,
    output logic [7:0]                   cpu_dat_out,
    output logic                         cpu_stall,
    output logic                         cpu_int,
    output logic [BUS_ADDR_DATA_LEN-1:0] spi_addr,
    output logic                         spi_wr,
    output logic                         spi_rd,
    output logic [7:0]                   spi_dat_out,
    input  logic [7:0]                   spi_dat_in,
    input  logic                         spi_int,
    output logic                         spi_int_rst
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_FETCH,
        ST_LOAD,
        ST_WAIT,
        ST_ACK,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [MEM_ADDR_LEN-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]        rem_q, rem_d;
    logic                    rx_en_q, rx_en_d;
    logic                    abort_seen_q, abort_seen_d;
    logic                    aborted_q, aborted_d;
    logic                    cpu_hits_spi;

    assign aborted      = aborted_q;
    assign cpu_hits_spi = (cpu_addr == SPCR_ADDR) || (cpu_addr == SPSR_ADDR) ||
                          (cpu_addr == SPDR_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            rem_q        <= '0;
            rx_en_q      <= 1'b0;
            abort_seen_q <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rem_q        <= rem_d;
            rx_en_q      <= rx_en_d;
            abort_seen_q <= abort_seen_d;
            aborted_q    <= aborted_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        rem_d        = rem_q;
        rx_en_d      = rx_en_q;
        abort_seen_d = abort_seen_q;
        aborted_d    = aborted_q;

        busy         = 1'b0;
        done         = 1'b0;
        cs_n         = 1'b1;
        mem_addr     = '0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_dat_out  = '0;
        spi_addr     = '0;
        spi_wr       = 1'b0;
        spi_rd       = 1'b0;
        spi_dat_out  = '0;
        spi_int_rst  = 1'b0;
        cpu_dat_out  = '0;
        cpu_int      = 1'b0;
        cpu_stall    = 1'b0;

        // The sequencer owns the master's bus in every state except IDLE.
        // Abort is latched here and only acted on at the next ACK, so the
        // byte in flight always completes.
        if (state_q != ST_IDLE) begin
            cpu_stall = (cpu_wr | cpu_rd) & cpu_hits_spi;
            if (abort) begin
                abort_seen_d = 1'b1;
                aborted_d    = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                spi_addr    = cpu_addr;
                spi_wr      = cpu_wr;
                spi_rd      = cpu_rd;
                spi_dat_out = cpu_dat_in;
                cpu_dat_out = spi_dat_in;
                cpu_int     = spi_int;
                if (start) begin
                    ptr_d        = base_addr;
                    rem_d        = length;
                    rx_en_d      = rx_en;
                    abort_seen_d = 1'b0;
                    aborted_d    = 1'b0;
                    state_d      = (length == '0) ? ST_DONE : ST_CFG;
                end
            end
            ST_CFG: begin
                busy        = 1'b1;
                spi_wr      = 1'b1;
                spi_addr    = SPCR_ADDR;
                spi_dat_out = SPCR_CFG;
                state_d     = ST_FETCH;
            end
            ST_FETCH: begin
                busy     = 1'b1;
                cs_n     = 1'b0;
                mem_rd   = 1'b1;
                mem_addr = ptr_q;
                state_d  = ST_LOAD;
            end
            ST_LOAD: begin
                busy        = 1'b1;
                cs_n        = 1'b0;
                spi_wr      = 1'b1;
                spi_addr    = SPDR_ADDR;
                spi_dat_out = mem_dat_in;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                cs_n = 1'b0;
                if (spi_int) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                busy        = 1'b1;
                cs_n        = 1'b0;
                spi_int_rst = 1'b1;
                spi_rd      = 1'b1;
                spi_addr    = SPDR_ADDR;
                if (rx_en_q) begin
                    mem_wr      = 1'b1;
                    mem_addr    = ptr_q;
                    mem_dat_out = spi_dat_in;
                end
                ptr_d = ptr_q + 1'b1;
                rem_d = rem_q - 1'b1;
                // rem_q == 1 means this ACK retires the last byte.
                if ((rem_q == LEN_W'(1)) || abort_seen_q || abort) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_burst_seq.sv
// tb_spi_burst_seq: self-checking bench for spi_burst_seq.
// Contains a behavioural SPI master (register file plus a random-latency
// transfer), a RAM model, and a bus monitor. Expected results are derived
// from a snapshot of RAM taken before each burst.
module tb_spi_burst_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic [11:0] length;
    logic        rx_en;
    logic        abort;
    logic        busy, done, aborted, cs_n;
    logic [11:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_dat_in, mem_dat_out;
    logic [7:0]  cpu_addr;
    logic        cpu_wr, cpu_rd;
    logic [7:0]  cpu_dat_in, cpu_dat_out;
    logic        cpu_stall, cpu_int;
    logic [7:0]  spi_addr;
    logic        spi_wr, spi_rd;
    logic [7:0]  spi_dat_out, spi_dat_in;
    logic        spi_int, spi_int_rst;

    spi_burst_seq dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .length(length), .rx_en(rx_en), .abort(abort), .busy(busy),
        .done(done), .aborted(aborted), .cs_n(cs_n), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_dat_in(mem_dat_in), .mem_wr(mem_wr),
        .mem_dat_out(mem_dat_out), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr),
        .cpu_rd(cpu_rd), .cpu_dat_in(cpu_dat_in), .cpu_dat_out(cpu_dat_out),
        .cpu_stall(cpu_stall), .cpu_int(cpu_int), .spi_addr(spi_addr),
        .spi_wr(spi_wr), .spi_rd(spi_rd), .spi_dat_out(spi_dat_out),
        .spi_dat_in(spi_dat_in), .spi_int(spi_int), .spi_int_rst(spi_int_rst)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- RAM model ----------------
    logic [7:0] ram     [0:4095];
    logic [7:0] ram_ref [0:4095];
    logic [7:0] rd_q;
    always @(posedge clk) begin
        if (mem_rd) rd_q <= ram[mem_addr];
        if (mem_wr) ram[mem_addr] <= mem_dat_out;
    end
    assign mem_dat_in = rd_q;

    // ---------------- SPI master model ----------------
    logic [7:0] m_spcr, m_rx, m_tx;
    logic       m_spif;
    int         m_cnt;
    bit         miso_inv;
    always @(posedge clk) begin
        if (rst) begin
            m_spcr <= 8'h00; m_rx <= 8'h00; m_tx <= 8'h00; m_spif <= 1'b0; m_cnt <= 0;
        end else begin
            if (spi_wr && spi_addr == 8'h20) m_spcr <= spi_dat_out;
            if (spi_wr && spi_addr == 8'h22 && m_cnt == 0) begin
                m_tx  <= spi_dat_out;
                m_cnt <= int'($urandom_range(2, 6));
            end else if (m_cnt == 1) begin
                m_rx   <= miso_inv ? ~m_tx : m_tx;
                m_spif <= 1'b1;
                m_cnt  <= 0;
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end
            if (spi_int_rst) m_spif <= 1'b0;
        end
    end
    assign spi_int    = m_spif & m_spcr[7];
    assign spi_dat_in = (spi_addr == 8'h22) ? m_rx :
                        (spi_addr == 8'h21) ? {m_spif, 7'b0} :
                        (spi_addr == 8'h20) ? m_spcr : 8'h00;

    // ---------------- bus monitor ----------------
    logic [7:0]  wr_addr_q[$];
    logic [7:0]  wr_dat_q[$];
    logic        wr_cs_q[$];
    logic [11:0] fetch_q[$];
    int          memwr_n, intrst_n, done_n, cs_err;
    bit          in_burst;
    always @(negedge clk) begin
        if (rst) begin
            in_burst = 1'b0;
        end else begin
            if (spi_wr) begin
                wr_addr_q.push_back(spi_addr);
                wr_dat_q.push_back(spi_dat_out);
                wr_cs_q.push_back(cs_n);
            end
            if (mem_rd) fetch_q.push_back(mem_addr);
            if (mem_wr) memwr_n++;
            if (spi_int_rst) intrst_n++;
            if (done) done_n++;
            // cs_n: low from the cycle after the config write until done.
            if (done) begin
                if (cs_n !== 1'b1) cs_err++;
                in_burst = 1'b0;
            end else if (in_burst) begin
                if (cs_n !== 1'b0) cs_err++;
            end else if (cs_n !== 1'b1) begin
                cs_err++;
            end
            if (spi_wr && spi_addr == 8'h20 && busy) in_burst = 1'b1;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int spdr_writes();
        int n = 0;
        foreach (wr_addr_q[i]) if (wr_addr_q[i] == 8'h22) n++;
        return n;
    endfunction

    task automatic clear_logs();
        wr_addr_q.delete(); wr_dat_q.delete(); wr_cs_q.delete(); fetch_q.delete();
        memwr_n = 0; intrst_n = 0; done_n = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input string tag);
        for (int c = 0; c < 400 && done_n == 0; c++) tick();
        check({tag, "_done_seen"}, 32'(done_n != 0), 32'd1);
    endtask

    // Issue a burst; optionally poke the CPU side mid-burst, or abort after
    // abort_at bytes have been loaded.
    task automatic run_burst(input string tag, input logic [11:0] b, input logic [11:0] l,
                             input logic rx, input int abort_at, input bit poke);
        foreach (ram[i]) ram_ref[i] = ram[i];
        clear_logs();
        base_addr = b; length = l; rx_en = rx; start = 1'b1;
        tick();
        start = 1'b0; base_addr = '0; length = '0; rx_en = 1'b0;
        if (poke) begin
            tick();
            cpu_addr = 8'h22; cpu_wr = 1'b1; cpu_dat_in = 8'h77;
            #1 check({tag, "_stall_spdr"}, 32'(cpu_stall), 32'd1);
            tick();
            cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 8'h30;
            #1 check({tag, "_nostall_30"}, 32'(cpu_stall), 32'd0);
            check({tag, "_cpu_dat_blk"}, 32'(cpu_dat_out), 32'd0);
            tick();
            cpu_rd = 1'b0; cpu_addr = 8'h00; cpu_dat_in = 8'h00;
        end
        if (abort_at > 0) begin
            for (int c = 0; c < 400 && spdr_writes() < abort_at; c++) tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        wait_done(tag);
    endtask

    // Reference: n bytes from the RAM snapshot, optional in-place writeback.
    task automatic verify(input string tag, input logic [11:0] b, input int n, input logic rx,
                          input logic exp_ab);
        logic [7:0]  exp_ram [0:4095];
        logic [11:0] a;
        int          bad = 0;
        foreach (ram_ref[i]) exp_ram[i] = ram_ref[i];
        check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(n + 1));
        if (wr_addr_q.size() == n + 1) begin
            check({tag, "_cfg_addr"}, 32'(wr_addr_q[0]), 32'h20);
            check({tag, "_cfg_dat"}, 32'(wr_dat_q[0]), 32'hD0);
            for (int i = 0; i < n; i++) begin
                a = 12'(b + 12'(i));
                if (wr_addr_q[i+1] !== 8'h22 || wr_dat_q[i+1] !== ram_ref[a] || wr_cs_q[i+1] !== 1'b0)
                    bad++;
                if (rx) exp_ram[a] = miso_inv ? ~ram_ref[a] : ram_ref[a];
            end
            check({tag, "_spdr_seq_bad"}, 32'(bad), 32'd0);
        end
        bad = 0;
        check({tag, "_nfetch"}, 32'(fetch_q.size()), 32'(n));
        foreach (fetch_q[i]) if (fetch_q[i] !== 12'(b + 12'(i))) bad++;
        check({tag, "_fetch_addr_bad"}, 32'(bad), 32'd0);
        check({tag, "_memwr"}, 32'(memwr_n), rx ? 32'(n) : 32'd0);
        check({tag, "_intrst"}, 32'(intrst_n), 32'(n));
        check({tag, "_done_cnt"}, 32'(done_n), 32'd1);
        check({tag, "_aborted"}, 32'(aborted), 32'(exp_ab));
        bad = 0;
        foreach (ram[i]) if (ram[i] !== exp_ram[i]) bad++;
        check({tag, "_ram_bad"}, 32'(bad), 32'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; rx_en = 1'b0; abort = 1'b0;
        cpu_addr = '0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_dat_in = '0; miso_inv = 1'b0;
        cs_err = 0;
        foreach (ram[i]) ram[i] = 8'($urandom);
        clear_logs();
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_aborted", 32'(aborted), 0);
        check("rst_cs_n", 32'(cs_n), 1);
        check("rst_mem_strobes", {30'd0, mem_rd, mem_wr}, 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_dat_out", 32'(mem_dat_out), 0);
        check("rst_spi_strobes", {29'd0, spi_wr, spi_rd, spi_int_rst}, 0);
        check("rst_cpu_stall", 32'(cpu_stall), 0);
        rst = 1'b0;
        tick();

        // Basic burst with CPU interference, echo MISO.
        ram[12'h100] = 8'hA5; ram[12'h101] = 8'h3C; ram[12'h102] = 8'hFF;
        run_burst("b3", 12'h100, 12'd3, 1'b0, 0, 1'b1);
        verify("b3", 12'h100, 3, 1'b0, 1'b0);

        // Pass-through after the burst.
        cpu_addr = 8'h21; cpu_rd = 1'b1;
        #1 check("pt_spsr_addr", 32'(spi_addr), 32'h21);
        check("pt_spsr_rd", 32'(spi_rd), 1);
        check("pt_spsr_dat", 32'(cpu_dat_out), 32'h00);
        check("pt_stall", 32'(cpu_stall), 0);
        cpu_addr = 8'h20;
        #1 check("pt_spcr_dat", 32'(cpu_dat_out), 32'hD0);
        cpu_rd = 1'b0; cpu_addr = 8'h00;
        tick();

        // Same burst with writeback of inverted MISO.
        miso_inv = 1'b1;
        run_burst("b3rx", 12'h100, 12'd3, 1'b1, 0, 1'b0);
        verify("b3rx", 12'h100, 3, 1'b1, 1'b0);
        check("b3rx_ram0", 32'(ram[12'h100]), 32'h5A);
        check("b3rx_ram1", 32'(ram[12'h101]), 32'hC3);
        check("b3rx_ram2", 32'(ram[12'h102]), 32'h00);

        // Zero-length burst.
        clear_logs();
        length = 12'd0; base_addr = 12'h123; start = 1'b1;
        tick();
        start = 1'b0;
        check("len0_done", 32'(done), 1);
        check("len0_busy", 32'(busy), 0);
        check("len0_cs_n", 32'(cs_n), 1);
        check("len0_spi_wr", 32'(spi_wr), 0);
        tick();
        check("len0_done_fall", 32'(done), 0);
        check("len0_nwrites", 32'(wr_addr_q.size()), 0);
        check("len0_done_cnt", 32'(done_n), 1);

        // Abort during byte 2.
        miso_inv = 1'b0;
        run_burst("abort", 12'h300, 12'd5, 1'b1, 2, 1'b0);
        verify("abort", 12'h300, 2, 1'b1, 1'b1);

        // Address wrap.
        run_burst("wrap", 12'hFFF, 12'd2, 1'b0, 0, 1'b0);
        verify("wrap", 12'hFFF, 2, 1'b0, 1'b0);

        // Random bursts.
        for (int k = 0; k < 6; k++) begin
            logic [11:0] b;
            logic [11:0] l;
            logic        rx;
            b  = 12'($urandom_range(0, 4095));
            l  = 12'($urandom_range(1, 9));
            rx = 1'($urandom_range(0, 1));
            miso_inv = 1'($urandom_range(0, 1));
            run_burst("rnd", b, l, rx, 0, 1'b0);
            verify("rnd", b, int'(l), rx, 1'b0);
        end

        // Reset mid-burst while waiting on the master.
        clear_logs();
        base_addr = 12'h200; length = 12'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 400 && spdr_writes() < 1; c++) tick();
        check("rstmid_in_burst", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_cs_n", 32'(cs_n), 1);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_done", 32'(done), 0);
        repeat (5) tick();
        check("rstmid_no_done", 32'(done_n), 0);

        check("cs_n_window_errors", 32'(cs_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
